// File: rtl/tproc_pkg.sv
// Shared types and constants for the tile processor datapath.
// Holds bank states and the kernel-size legality check.
package tproc_pkg;

    localparam int unsigned KMAX = 5;
    localparam int unsigned FW   = 8;

    typedef enum logic [1:0] {
        StEmpty,
        StFilling,
        StFull
    } bank_state_e;

    // Kernel sizes must be odd and within 1..kmax.
    function automatic logic k_legal(input int unsigned k, input int unsigned kmax = KMAX);
        return (k >= 1) && (k <= kmax) && k[0];
    endfunction

endpackage

// File: rtl/window_col_buffer_if.sv
// Column-in / window-out handshake bundle for window_col_buffer.
interface window_col_buffer_if #(
    parameter int unsigned TN   = 4,
    parameter int unsigned KMAX = tproc_pkg::KMAX,
    parameter int unsigned FW   = tproc_pkg::FW,
    parameter int unsigned KW   = $clog2(KMAX + 1)
);

    logic [KW-1:0]               cfg_k;
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_sel;
    logic [TN*KMAX*FW-1:0]       din_0;
    logic [TN*KMAX*FW-1:0]       din_1;
    logic                        out_valid;
    logic                        out_ready;
    logic [TN*KMAX*KMAX*FW-1:0]  dout;
    logic [KW-1:0]               out_k;
    logic                        cfg_err;

    modport master (
        output cfg_k, in_valid, in_sel, din_0, din_1, out_ready,
        input  in_ready, out_valid, dout, out_k, cfg_err
    );

    modport slave (
        input  cfg_k, in_valid, in_sel, din_0, din_1, out_ready,
        output in_ready, out_valid, dout, out_k, cfg_err
    );

endinterface

// File: rtl/win_bank.sv
// One window bank: per-group KxK storage, latched k and column count.
// New columns enter at the top of the window after a k-element left shift.
module win_bank #(
    parameter int unsigned TN   = 4,
    parameter int unsigned KMAX = tproc_pkg::KMAX,
    parameter int unsigned FW   = tproc_pkg::FW,
    parameter int unsigned KW   = $clog2(KMAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [KW-1:0]              cfg_k,
    input  logic [TN*KMAX*FW-1:0]      col_data,
    output tproc_pkg::bank_state_e     state,
    output logic [KW-1:0]              k,
    output logic                       win_done,
    output logic                       k_bad,
    output logic [TN*KMAX*KMAX*FW-1:0] window
);
    import tproc_pkg::*;

    localparam int unsigned NE = KMAX * KMAX;
    localparam int unsigned CW = $clog2(KMAX);

    bank_state_e   state_q, state_d;
    logic [KW-1:0] k_q, k_d, k_eff;
    logic [CW-1:0] col_q, col_d;
    logic [FW-1:0] win_q [TN][NE];
    logic [FW-1:0] win_d [TN][NE];
    logic          cfg_ok;
    int unsigned   ki;
    int unsigned   k2;

    always_comb begin
        cfg_ok   = k_legal(32'(cfg_k), KMAX);
        k_eff    = (col_q == '0) ? (cfg_ok ? cfg_k : KW'(KMAX)) : k_q;
        ki       = 32'(k_eff);
        state_d  = state_q;
        k_d      = k_q;
        col_d    = col_q;
        win_d    = win_q;
        win_done = 1'b0;
        k_bad    = 1'b0;
        if (pop) begin
            state_d = StEmpty;
            col_d   = '0;
            for (int unsigned g = 0; g < TN; g++) begin
                for (int unsigned i = 0; i < NE; i++) begin
                    win_d[g][i] = '0;
                end
            end
        end else if (push) begin
            k_d   = k_eff;
            k_bad = (col_q == '0) && !cfg_ok;
            for (int unsigned g = 0; g < TN; g++) begin
                for (int unsigned i = 0; i < NE; i++) begin
                    if (i < (ki - 1) * ki) begin
                        win_d[g][i] = win_q[g][i + ki];
                    end else if (i < ki * ki) begin
                        win_d[g][i] = col_data[(g * KMAX + i - (ki - 1) * ki) * FW +: FW];
                    end else begin
                        win_d[g][i] = '0;
                    end
                end
            end
            if (32'(col_q) == ki - 1) begin
                win_done = 1'b1;
                col_d    = '0;
                state_d  = StFull;
            end else begin
                col_d   = col_q + 1'b1;
                state_d = StFilling;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            k_q     <= '0;
            col_q   <= '0;
            for (int unsigned g = 0; g < TN; g++) begin
                for (int unsigned i = 0; i < NE; i++) begin
                    win_q[g][i] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            col_q   <= col_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        k2     = 32'(k_q) * 32'(k_q);
        window = '0;
        for (int unsigned g = 0; g < TN; g++) begin
            for (int unsigned i = 0; i < NE; i++) begin
                if (i < k2) window[(g * NE + i) * FW +: FW] = win_q[g][i];
            end
        end
    end

    assign state = state_q;
    assign k     = k_q;

endmodule

// File: rtl/window_col_buffer.sv
// Double-buffered column-to-window assembler: one bank fills while the
// other presents a completed window on a valid/ready output.
module window_col_buffer #(
    parameter int unsigned TN   = 4,
    parameter int unsigned KMAX = tproc_pkg::KMAX,
    parameter int unsigned FW   = tproc_pkg::FW,
    parameter int unsigned KW   = $clog2(KMAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    window_col_buffer_if.slave  bus
);
    import tproc_pkg::*;

    localparam int unsigned DINW = TN * KMAX * FW;
    localparam int unsigned DW   = TN * KMAX * KMAX * FW;

    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            cfg_err_q, cfg_err_d;
    logic            accept, fire;
    logic [1:0]      push_b, pop_b, done_b, bad_b;
    bank_state_e     st_b  [2];
    logic [KW-1:0]   k_b   [2];
    logic [DW-1:0]   win_b [2];
    logic [DINW-1:0] col_data;

    assign col_data = bus.in_sel ? bus.din_1 : bus.din_0;

    // Handshake outputs depend only on registered bank state and pointers.
    assign bus.in_ready  = (st_b[wr_ptr_q] != StFull);
    assign bus.out_valid = (st_b[rd_ptr_q] == StFull);
    assign bus.dout      = win_b[rd_ptr_q];
    assign bus.out_k     = k_b[rd_ptr_q];
    assign bus.cfg_err   = cfg_err_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign fire   = bus.out_valid & bus.out_ready;

    assign push_b = {accept & wr_ptr_q, accept & ~wr_ptr_q};
    assign pop_b  = {fire & rd_ptr_q, fire & ~rd_ptr_q};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        win_bank #(
            .TN   (TN),
            .KMAX (KMAX),
            .FW   (FW),
            .KW   (KW)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .push     (push_b[b]),
            .pop      (pop_b[b]),
            .cfg_k    (bus.cfg_k),
            .col_data (col_data),
            .state    (st_b[b]),
            .k        (k_b[b]),
            .win_done (done_b[b]),
            .k_bad    (bad_b[b]),
            .window   (win_b[b])
        );
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q ^ done_b[wr_ptr_q];
        rd_ptr_d  = rd_ptr_q ^ fire;
        cfg_err_d = cfg_err_q | (|bad_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cfg_err_q <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_window_col_buffer.sv
// Directed self-checking bench for window_col_buffer.
module tb_window_col_buffer;

    localparam int unsigned TN   = 4;
    localparam int unsigned KMAX = 5;
    localparam int unsigned FW   = 8;
    localparam int unsigned KW   = 3;
    localparam int unsigned NE   = KMAX * KMAX;
    localparam int unsigned DINW = TN * KMAX * FW;
    localparam int unsigned DW   = TN * NE * FW;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    window_col_buffer_if #(.TN(TN), .KMAX(KMAX), .FW(FW), .KW(KW)) bus ();

    window_col_buffer #(
        .TN   (TN),
        .KMAX (KMAX),
        .FW   (FW),
        .KW   (KW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pixel = {g[1:0], c[2:0], r[2:0]} xor a per-window tag.
    function automatic logic [7:0] pix(input logic [7:0] tag, input int g, input int c,
                                       input int r);
        return ((8'(g) << 6) | (8'(c) << 3) | 8'(r)) ^ tag;
    endfunction

    function automatic logic [DINW-1:0] col_vec(input logic [7:0] tag, input int c,
                                                input int k);
        logic [DINW-1:0] v;
        for (int g = 0; g < int'(TN); g++) begin
            for (int r = 0; r < int'(KMAX); r++) begin
                v[(g * KMAX + r) * FW +: FW] = (r < k) ? pix(tag, g, c, r) : 8'hFF;
            end
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] exp_win(input logic [7:0] tag, input int k);
        logic [DW-1:0] v;
        v = '0;
        for (int g = 0; g < int'(TN); g++) begin
            for (int c = 0; c < k; c++) begin
                for (int r = 0; r < k; r++) begin
                    v[(g * NE + c * k + r) * FW +: FW] = pix(tag, g, c, r);
                end
            end
        end
        return v;
    endfunction

    // Column goes on the input chosen by c's parity; the other input carries junk.
    task automatic send_col(input logic [7:0] tag, input int c, input int k);
        int n;
        n = 0;
        bus.in_sel = 1'(c % 2);
        if (c % 2 == 1) begin
            bus.din_1 = col_vec(tag, c, k);
            bus.din_0 = {(DINW / 8){8'hEE}};
        end else begin
            bus.din_0 = col_vec(tag, c, k);
            bus.din_1 = {(DINW / 8){8'hEE}};
        end
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_in_ready", DW'(bus.in_ready), DW'(1));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_win();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic drive_stream(input int i);
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'(i % 2);
        bus.din_0    = col_vec(8'(i), 0, 1);
        bus.din_1    = col_vec(8'(i + 32), 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nff;
        int n_win;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 1'b0;
        bus.din_0     = '0;
        bus.din_1     = '0;
        bus.cfg_k     = 3'd5;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check_eq("rst_in_ready", DW'(bus.in_ready), DW'(1));
        check_eq("rst_out_valid", DW'(bus.out_valid), DW'(0));
        check_eq("rst_dout", bus.dout, '0);
        check_eq("rst_out_k", DW'(bus.out_k), DW'(0));
        check_eq("rst_cfg_err", DW'(bus.cfg_err), DW'(0));

        // k=5 basic window
        bus.cfg_k = 3'd5;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) check_eq("k5_not_early", DW'(bus.out_valid), DW'(0));
            send_col(8'h00, c, 5);
        end
        check_eq("k5_valid", DW'(bus.out_valid), DW'(1));
        check_eq("k5_dout", bus.dout, exp_win(8'h00, 5));
        check_eq("k5_out_k", DW'(bus.out_k), DW'(5));
        check_eq("k5_cfg_err", DW'(bus.cfg_err), DW'(0));
        pop_win();
        check_eq("k5_drained", DW'(bus.out_valid), DW'(0));

        // k=3 with unused rows driven to 0xFF
        bus.cfg_k = 3'd3;
        for (int c = 0; c < 3; c++) send_col(8'h10, c, 3);
        check_eq("k3_valid", DW'(bus.out_valid), DW'(1));
        check_eq("k3_dout", bus.dout, exp_win(8'h10, 3));
        check_eq("k3_out_k", DW'(bus.out_k), DW'(3));
        nff = 0;
        for (int i = 0; i < int'(TN * NE); i++) begin
            if (bus.dout[i * FW +: FW] == 8'hFF) nff++;
        end
        check_eq("k3_no_ff", DW'(nff), DW'(0));
        pop_win();

        // Back-pressure: two windows queue up, then drain in order
        bus.cfg_k = 3'd5;
        for (int c = 0; c < 5; c++) send_col(8'h01, c, 5);
        check_eq("bp_first_valid", DW'(bus.out_valid), DW'(1));
        check_eq("bp_ready_mid", DW'(bus.in_ready), DW'(1));
        for (int c = 0; c < 5; c++) send_col(8'h02, c, 5);
        check_eq("bp_ready_low", DW'(bus.in_ready), DW'(0));
        check_eq("bp_dout_hold", bus.dout, exp_win(8'h01, 5));
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        bus.din_0    = col_vec(8'h07, 0, 5);
        repeat (3) @(negedge clk);
        check_eq("bp_ready_still_low", DW'(bus.in_ready), DW'(0));
        check_eq("bp_dout_stable", bus.dout, exp_win(8'h01, 5));
        check_eq("bp_valid_stable", DW'(bus.out_valid), DW'(1));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_second_valid", DW'(bus.out_valid), DW'(1));
        check_eq("bp_second_dout", bus.dout, exp_win(8'h02, 5));
        check_eq("bp_ready_back", DW'(bus.in_ready), DW'(1));
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_drained", DW'(bus.out_valid), DW'(0));
        bus.out_ready = 1'b0;

        // k=1 streaming with alternating source select
        bus.cfg_k     = 3'd1;
        bus.out_ready = 1'b1;
        n_win         = 0;
        drive_stream(0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) n_win++;
            check_eq("st_valid", DW'(bus.out_valid), DW'(1));
            check_eq("st_ready", DW'(bus.in_ready), DW'(1));
            check_eq("st_dout", bus.dout, exp_win((i % 2 == 1) ? 8'(i + 32) : 8'(i), 1));
            if (i < 19) drive_stream(i + 1);
            else bus.in_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("st_count", DW'(n_win), DW'(20));
        check_eq("st_drained", DW'(bus.out_valid), DW'(0));
        bus.out_ready = 1'b0;

        // Illegal k=4 falls back to KMAX and sets the sticky error
        bus.cfg_k = 3'd4;
        send_col(8'h03, 0, 5);
        check_eq("ill_err_set", DW'(bus.cfg_err), DW'(1));
        for (int c = 1; c < 4; c++) send_col(8'h03, c, 5);
        check_eq("ill_not_early", DW'(bus.out_valid), DW'(0));
        send_col(8'h03, 4, 5);
        check_eq("ill_valid", DW'(bus.out_valid), DW'(1));
        check_eq("ill_out_k", DW'(bus.out_k), DW'(5));
        check_eq("ill_dout", bus.dout, exp_win(8'h03, 5));
        pop_win();

        // Legal k=3 window with a mid-window cfg_k change that must be ignored
        bus.cfg_k = 3'd3;
        send_col(8'h04, 0, 3);
        bus.cfg_k = 3'd5;
        send_col(8'h04, 1, 3);
        send_col(8'h04, 2, 3);
        check_eq("mid_valid", DW'(bus.out_valid), DW'(1));
        check_eq("mid_out_k", DW'(bus.out_k), DW'(3));
        check_eq("mid_dout", bus.dout, exp_win(8'h04, 3));
        check_eq("ill_err_sticky", DW'(bus.cfg_err), DW'(1));
        pop_win();

        // Reset after two of five columns
        bus.cfg_k = 3'd5;
        send_col(8'h05, 0, 5);
        send_col(8'h05, 1, 5);
        rst = 1'b1;
        #2;
        check_eq("mr_out_valid", DW'(bus.out_valid), DW'(0));
        check_eq("mr_dout", bus.dout, '0);
        check_eq("mr_in_ready", DW'(bus.in_ready), DW'(1));
        check_eq("mr_cfg_err", DW'(bus.cfg_err), DW'(0));
        check_eq("mr_out_k", DW'(bus.out_k), DW'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 5; c++) send_col(8'h06, c, 5);
        check_eq("mr_fresh_valid", DW'(bus.out_valid), DW'(1));
        check_eq("mr_fresh_dout", bus.dout, exp_win(8'h06, 5));
        pop_win();
        check_eq("mr_drained", DW'(bus.out_valid), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
